rll_seq_key_lock: RTL

Parametrised, sequential successor to the fixed 16-key random-logic-locked benchmarks. The block loads the key serially over a handshake and applies it to a 2-stage valid/ready datapath through per-bit XOR/XNOR key gates. The datapath passes data unaltered only when the loaded key equals the compile-time polarity mask. It sits between a key-programming port (scan/OTP model) and the locked payload datapath in generated benchmarks.

---
 rtl/rll_pkg.sv | 22 ++
 rtl/rll_key_shifter.sv | 58 +++++
 rtl/rll_seq_key_lock.sv | 123 ++++++++++++
 3 files changed

// File: rtl/rll_pkg.sv
// Shared types and helpers for the sequential key-locked datapath.
package rll_pkg;

    typedef enum logic [1:0] {
        UNKEYED = 2'd0,
        LOADING = 2'd1,
        ARMED   = 2'd2
    } rll_state_t;

    localparam int LOAD_CNT_W = 8;

    // Widest datapath the mask helper supports; callers zero-extend and truncate.
    localparam int MASK_MAX_W = 256;

    function automatic logic [MASK_MAX_W-1:0] build_mask(
        input logic [MASK_MAX_W-1:0] key,
        input logic [MASK_MAX_W-1:0] pol
    );
        return key ^ pol;
    endfunction

endpackage

// File: rtl/rll_key_shifter.sv
// Serial key capture: LSB-first shadow register, bit counter and optional
// even-parity check on a trailing bit (RLL_KEY_PARITY_EN).
module rll_key_shifter
    import rll_pkg::*;
#(
    parameter int KEY_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             shift_en,
    input  logic             bit_in,
    output logic             done,
    output logic             parity_ok,
    output logic [KEY_W-1:0] key_next
);

`ifdef RLL_KEY_PARITY_EN
    localparam int NBITS = KEY_W + 1;
`else
    localparam int NBITS = KEY_W;
`endif
    localparam int IDX_W = $clog2(NBITS + 1);

    logic [KEY_W-1:0] shadow;
    logic [IDX_W-1:0] bit_idx;
    logic             last_bit;

    assign last_bit = (bit_idx == IDX_W'(NBITS - 1));
    assign done     = shift_en && last_bit;

    // Shadow with the current bit merged in, so the FSM can commit on the same edge.
    always_comb begin
        key_next = shadow;
        for (int i = 0; i < KEY_W; i++) begin
            if (bit_idx == IDX_W'(i)) begin
                key_next[i] = bit_in;
            end
        end
    end

`ifdef RLL_KEY_PARITY_EN
    assign parity_ok = ((^shadow) == bit_in);
`else
    assign parity_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst || start) begin
            shadow  <= '0;
            bit_idx <= '0;
        end else if (shift_en) begin
            shadow  <= key_next;
            bit_idx <= last_bit ? '0 : bit_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/rll_seq_key_lock.sv
// Sequential key-locked datapath: serial key load feeding XOR/XNOR key gates
// in front of a 2-stage valid/ready pipeline. Optional macro: RLL_KEY_PARITY_EN.
//
// state   | meaning
// UNKEYED | no valid key, datapath closed
// LOADING | shifting key bits into the shadow register
// ARMED   | key committed, datapath accepting words
module rll_seq_key_lock
    import rll_pkg::*;
#(
    parameter int               DATA_W  = 32,
    parameter int               KEY_W   = 16,
    parameter logic [KEY_W-1:0] KEY_POL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  key_start,
    input  logic                  key_valid,
    input  logic                  key_bit,
    output logic                  key_armed,
    output logic                  key_err,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [LOAD_CNT_W-1:0] load_cnt
);

    rll_state_t        state;
    logic [KEY_W-1:0]  key_reg;
    logic [KEY_W-1:0]  key_next;
    logic              shift_en;
    logic              key_done;
    logic              key_parity_ok;
    logic [DATA_W-1:0] gate_mask;

    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic              s2_valid;
    logic [DATA_W-1:0] s2_data;
    logic              s2_free;
    logic              s1_move;
    logic              s1_free;
    logic              in_fire;

    // A start in the same cycle discards the bit.
    assign shift_en = (state == LOADING) && key_valid && !key_start;

    rll_key_shifter #(
        .KEY_W (KEY_W)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .start     (key_start),
        .shift_en  (shift_en),
        .bit_in    (key_bit),
        .done      (key_done),
        .parity_ok (key_parity_ok),
        .key_next  (key_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= UNKEYED;
            key_reg   <= '0;
            key_armed <= 1'b0;
            key_err   <= 1'b0;
            load_cnt  <= '0;
        end else if (key_start) begin
            state     <= LOADING;
            key_armed <= 1'b0;
            key_err   <= 1'b0;
        end else if (state == LOADING && key_done) begin
            if (key_parity_ok) begin
                state     <= ARMED;
                key_reg   <= key_next;
                key_armed <= 1'b1;
                if (load_cnt != '1) begin
                    load_cnt <= load_cnt + LOAD_CNT_W'(1);
                end
            end else begin
                state   <= UNKEYED;
                key_err <= 1'b1;
            end
        end
    end

    // Key bits map onto the low bits of the word; upper bits pass through.
    assign gate_mask = DATA_W'(build_mask(MASK_MAX_W'(key_reg), MASK_MAX_W'(KEY_POL)));

    assign s2_free   = !s2_valid || out_ready;
    assign s1_move   = s1_valid && s2_free;
    assign s1_free   = !s1_valid || s1_move;
    assign in_ready  = (state == ARMED) && s1_free;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = s2_valid;
    assign out_data  = s2_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else begin
            if (s2_free) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= s1_data;
                end
            end
            if (in_fire) begin
                s1_valid <= 1'b1;
                s1_data  <= in_data ^ gate_mask;
            end else if (s1_move) begin
                s1_valid <= 1'b0;
            end
        end
    end

endmodule
